pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection (sequential, branch, jump,
// RAS return, exception) and a circular return-address stack with sticky underflow flag.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(32'h00000000),
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h00000080),
  parameter int               DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     stall,
  input  logic                     exc,
  input  logic                     br_taken,
  input  logic [WIDTH-1:0]         br_target,
  input  logic                     jump,
  input  logic [WIDTH-1:0]         jump_target,
  input  logic                     ras_push,
  input  logic                     ras_pop,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_next_seq,
  output logic [WIDTH-1:0]         ras_top,
  output logic [$clog2(DEPTH):0]   ras_count,
  output logic                     ras_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_ras_top;
  logic [PTR_W-1:0] w_top_inc;
  logic [PTR_W-1:0] w_top_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_active;

  assign w_pc_seq  = r_pc + WIDTH'(INC);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_top_dec = r_top - PTR_W'(1);
  assign w_ras_top = w_empty ? '0 : r_ras[r_top];
  // RAS and error flag only move on a cycle that is neither stalled nor excepted.
  assign w_active  = !exc && !stall;

  always_comb begin
    w_pc_nxt = w_pc_seq;
    if (exc) begin
      w_pc_nxt = EXC_VEC;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (ras_pop && !w_empty) begin
      w_pc_nxt = w_ras_top;
    end else if (ras_pop) begin
      w_pc_nxt = w_pc_seq;
    end else if (jump) begin
      w_pc_nxt = jump_target & ALIGN_MASK;
    end else if (br_taken) begin
      w_pc_nxt = br_target & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_pc    <= RESET_VEC;
      r_top   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_active) begin
        if (ras_push && ras_pop && !w_empty) begin
          // Call and return in one instruction: swap the top entry in place.
          r_ras[r_top] <= w_pc_seq;
        end else if (ras_push) begin
          // A push when full overwrites the oldest slot, which is the one above top.
          r_ras[w_top_inc] <= w_pc_seq;
          r_top            <= w_top_inc;
          if (!w_full) r_count <= r_count + CNT_W'(1);
        end else if (ras_pop && !w_empty) begin
          r_top   <= w_top_dec;
          r_count <= r_count - CNT_W'(1);
        end
        if (ras_pop && w_empty) r_err <= 1'b1;
      end
    end
  end

  assign pc          = r_pc;
  assign pc_next_seq = w_pc_seq;
  assign ras_top     = w_ras_top;
  assign ras_count   = r_count;
  assign ras_err     = r_err;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: each cycle's expected PC is queued with the
// stimulus and popped for comparison one clock later.
module tb_pc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         R = 1'b1;
  logic         stall = 1'b0;
  logic         exc = 1'b0;
  logic         br_taken = 1'b0;
  logic [W-1:0] br_target = '0;
  logic         jump = 1'b0;
  logic [W-1:0] jump_target = '0;
  logic         ras_push = 1'b0;
  logic         ras_pop = 1'b0;
  logic [W-1:0] pc;
  logic [W-1:0] pc_next_seq;
  logic [W-1:0] ras_top;
  logic [2:0]   ras_count;
  logic         ras_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;
  int n_checks = 0;
  int n_pass = 0;

  pc_unit #(
    .WIDTH(32), .INC(4), .ALIGN_BITS(2),
    .RESET_VEC(32'h00000000), .EXC_VEC(32'h00000080), .DEPTH(4)
  ) dut (
    .clk(clk), .R(R), .stall(stall), .exc(exc),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .ras_push(ras_push), .ras_pop(ras_pop),
    .pc(pc), .pc_next_seq(pc_next_seq), .ras_top(ras_top),
    .ras_count(ras_count), .ras_err(ras_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // drivers
  task automatic idle_inputs();
    R = 1'b0; stall = 1'b0; exc = 1'b0; br_taken = 1'b0; jump = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0; br_target = '0; jump_target = '0;
  endtask

  task automatic step(input logic [W-1:0] exp_pc);
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    R = 1'b1;
    step(32'h0);
    void'(exp_q.pop_front());
  endtask

  task automatic goto_pc(input logic [W-1:0] target);
    jump = 1'b1; jump_target = target;
    step(target);
    void'(exp_q.pop_front());
  endtask

  // tests
  task automatic test_reset();
    R = 1'b1; exc = 1'b1; stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
    step(32'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd0 || ras_err !== 1'b0 || ras_top !== '0)
      $display("FAIL reset: pc=%h cnt=%0d err=%b top=%h want pc=%h cnt=0 err=0 top=0",
               pc, ras_count, ras_err, ras_top, exp);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      step(W'(4 * i));
      exp = exp_q.pop_front();
      n_checks++;
      if (pc !== exp || pc_next_seq !== exp + 32'd4)
        $display("FAIL seq%0d: pc=%h nseq=%h want pc=%h", i, pc, pc_next_seq, exp);
      else n_pass++;
    end
  endtask

  task automatic test_jump_priority();
    goto_pc(32'h10);
    jump = 1'b1; jump_target = 32'h203; br_taken = 1'b1; br_target = 32'h400;
    step(32'h200);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp) $display("FAIL jump_over_br: pc=%h want %h", pc, exp);
    else n_pass++;
    br_taken = 1'b1; br_target = 32'h403;
    step(32'h400);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp) $display("FAIL br_align: pc=%h want %h", pc, exp);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    do_reset();
    goto_pc(32'h10);
    ras_push = 1'b1;
    step(32'h14);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd1 || ras_top !== 32'h14)
      $display("FAIL push: pc=%h cnt=%0d top=%h want pc=%h cnt=1 top=14", pc, ras_count, ras_top, exp);
    else n_pass++;
    goto_pc(32'h40);
    ras_pop = 1'b1;
    step(32'h14);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd0 || ras_top !== '0 || ras_err !== 1'b0)
      $display("FAIL pop: pc=%h cnt=%0d top=%h err=%b want pc=%h cnt=0 top=0 err=0",
               pc, ras_count, ras_top, ras_err, exp);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [W-1:0] pops[4] = '{32'h14, 32'h10, 32'hC, 32'h8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1;
      step(W'(4 * (i + 1)));
      exp = exp_q.pop_front();
      n_checks++;
      if (pc !== exp || ras_top !== exp || ras_count !== 3'((i + 1 > 4) ? 4 : i + 1))
        $display("FAIL push%0d: pc=%h top=%h cnt=%0d want %h", i, pc, ras_top, ras_count, exp);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      ras_pop = 1'b1;
      step(pops[i]);
      exp = exp_q.pop_front();
      n_checks++;
      if (pc !== exp || ras_count !== 3'(3 - i) || ras_err !== 1'b0)
        $display("FAIL popfull%0d: pc=%h cnt=%0d err=%b want pc=%h cnt=%0d", i, pc, ras_count, ras_err, exp, 3 - i);
      else n_pass++;
    end
    ras_pop = 1'b1;
    step(32'hC);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd0 || ras_err !== 1'b1)
      $display("FAIL underflow: pc=%h cnt=%0d err=%b want pc=%h cnt=0 err=1", pc, ras_count, ras_err, exp);
    else n_pass++;
    step(32'h10);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_err !== 1'b1)
      $display("FAIL err_sticky: pc=%h err=%b want pc=%h err=1", pc, ras_err, exp);
    else n_pass++;
  endtask

  task automatic test_push_pop_same();
    do_reset();
    ras_push = 1'b1;
    step(32'h4);
    void'(exp_q.pop_front());
    goto_pc(32'h30);
    ras_push = 1'b1; ras_pop = 1'b1;
    step(32'h4);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd1 || ras_top !== 32'h34)
      $display("FAIL pushpop: pc=%h cnt=%0d top=%h want pc=%h cnt=1 top=34", pc, ras_count, ras_top, exp);
    else n_pass++;
    ras_pop = 1'b1;
    step(32'h34);
    void'(exp_q.pop_front());
    ras_push = 1'b1; ras_pop = 1'b1;
    step(32'h38);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd1 || ras_top !== 32'h38 || ras_err !== 1'b1)
      $display("FAIL pushpop_empty: pc=%h cnt=%0d top=%h err=%b want pc=%h cnt=1 top=38 err=1",
               pc, ras_count, ras_top, ras_err, exp);
    else n_pass++;
  endtask

  task automatic test_stall_exc();
    do_reset();
    ras_push = 1'b1;
    step(32'h4);
    void'(exp_q.pop_front());
    goto_pc(32'h20);
    stall = 1'b1; jump = 1'b1; jump_target = 32'h300; ras_push = 1'b1;
    step(32'h20);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd1 || ras_top !== 32'h4)
      $display("FAIL stall: pc=%h cnt=%0d top=%h want pc=%h cnt=1 top=4", pc, ras_count, ras_top, exp);
    else n_pass++;
    stall = 1'b1; exc = 1'b1; ras_pop = 1'b1;
    step(32'h80);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_count !== 3'd1 || ras_top !== 32'h4 || ras_err !== 1'b0)
      $display("FAIL exc: pc=%h cnt=%0d top=%h err=%b want pc=%h cnt=1 top=4 err=0",
               pc, ras_count, ras_top, ras_err, exp);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset_exc();
    goto_pc(32'hFFFFFFFC);
    step(32'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp) $display("FAIL wrap: pc=%h want %h", pc, exp);
    else n_pass++;
    do_reset();
    ras_pop = 1'b1;
    step(32'h4);
    void'(exp_q.pop_front());
    R = 1'b1; exc = 1'b1;
    step(32'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (pc !== exp || ras_err !== 1'b0 || ras_count !== 3'd0)
      $display("FAIL reset_exc: pc=%h err=%b cnt=%0d want pc=%h err=0 cnt=0", pc, ras_err, ras_count, exp);
    else n_pass++;
  endtask

  task automatic test_random_branch();
    logic [W-1:0] model_pc;
    do_reset();
    model_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      br_taken  = 1'($urandom_range(0, 1));
      br_target = $urandom;
      model_pc  = br_taken ? (br_target & 32'hFFFFFFFC) : model_pc + 32'd4;
      step(model_pc);
      exp = exp_q.pop_front();
      n_checks++;
      if (pc !== exp) $display("FAIL rand_br%0d: pc=%h want %h", i, pc, exp);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    R = 1'b1;
    test_reset();
    test_jump_priority();
    test_push_pop();
    test_ras_overflow();
    test_push_pop_same();
    test_stall_exc();
    test_wrap_and_reset_exc();
    test_random_branch();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
